// File: rtl/sccb_bus_arbiter_if.sv
// Requester and transaction-engine signals of the SCCB bus arbiter.
// master = arbiter side, slave = requesters plus engine.
interface sccb_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    iREQ;
  logic [24*NUM_REQ-1:0] iWDATA;
  logic [NUM_REQ-1:0]    iWR;
  logic [NUM_REQ-1:0]    oGNT;
  logic [NUM_REQ-1:0]    oDONE;
  logic [NUM_REQ-1:0]    oERR;
  logic [7:0]            oRDATA;
  logic                  oBUSY;
  logic                  oENG_GO;
  logic                  oENG_WR;
  logic [23:0]           oENG_WDATA;
  logic                  iENG_END;
  logic                  iENG_ACK;
  logic [7:0]            iENG_RDATA;

  modport master (
    input  iREQ, iWDATA, iWR, iENG_END, iENG_ACK, iENG_RDATA,
    output oGNT, oDONE, oERR, oRDATA, oBUSY, oENG_GO, oENG_WR, oENG_WDATA
  );

  modport slave (
    output iREQ, iWDATA, iWR, iENG_END, iENG_ACK, iENG_RDATA,
    input  oGNT, oDONE, oERR, oRDATA, oBUSY, oENG_GO, oENG_WR, oENG_WDATA
  );
endinterface

// File: rtl/sccb_bus_arbiter.sv
// Round-robin arbiter sharing one SCCB transaction engine, with NACK retry.
// Optional engine watchdog enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_bus_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input logic                  iCLK,
  input logic                  iRST,
  sccb_bus_arbiter_if.master   bus
);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitEnd, StGap, StResp} state_e;

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_err;
  logic [7:0]           r_rdata;
  logic                 r_busy;
  logic                 r_go;
  logic                 r_wr;
  logic [23:0]          r_wdata;
  logic [PW-1:0]        r_ptr;
  logic [RW-1:0]        r_retry;
  logic [GW-1:0]        r_gap;

  logic                 w_any;
  logic                 w_grant;
  logic [PW-1:0]        w_sel;
  logic [PW-1:0]        w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_onehot;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]        r_to;
  logic                 r_wait_end;
`else
  logic [31:0]          w_unused_to;
  assign w_unused_to = TIMEOUT_CYC;
`endif

  // First requester at or after the RR pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_any && bus.iREQ[PW'((int'(r_ptr) + i) % int'(NUM_REQ))]) begin
        w_any = 1'b1;
        w_sel = PW'((int'(r_ptr) + i) % int'(NUM_REQ));
      end
    end
  end

  assign w_ptr_nxt = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

`ifdef SCCB_ARB_TIMEOUT_EN
  // After a timeout the engine may still be busy; hold off new grants.
  assign w_grant = w_any && (!r_wait_end || bus.iENG_END);
`else
  assign w_grant = w_any;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_go    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_retry <= '0;
      r_gap   <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
      r_to       <= '0;
      r_wait_end <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        StIdle: begin
`ifdef SCCB_ARB_TIMEOUT_EN
          if (bus.iENG_END) r_wait_end <= 1'b0;
          r_to <= '0;
`endif
          if (w_grant) begin
            r_wdata <= bus.iWDATA[24*w_sel +: 24];
            r_wr    <= bus.iWR[w_sel];
            r_gnt   <= w_onehot;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= StLaunch;
          end
        end
        StLaunch: begin
          r_go <= 1'b1;
          // END low only counts once the engine has seen GO.
          if (r_go && !bus.iENG_END) r_state <= StWaitEnd;
        end
        StWaitEnd: begin
          if (bus.iENG_END) begin
            r_go <= 1'b0;
            if (bus.iENG_ACK && (r_retry < RW'(MAX_RETRY))) begin
              r_retry <= r_retry + 1'b1;
              r_gap   <= '0;
              r_state <= StGap;
            end else begin
              r_done  <= r_gnt;
              r_err   <= bus.iENG_ACK ? r_gnt : '0;
              if (!r_wr) r_rdata <= bus.iENG_RDATA;
              r_state <= StResp;
            end
          end
        end
        StGap: begin
          if (r_gap == GW'(GAP_CYC - 1)) begin
            r_state <= StLaunch;
`ifdef SCCB_ARB_TIMEOUT_EN
            r_to <= '0;
`endif
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        StResp: begin
          r_gnt   <= '0;
          r_retry <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
`ifdef SCCB_ARB_TIMEOUT_EN
      // Watchdog overrides the case above: abort without retry.
      if ((r_state == StLaunch) || (r_state == StWaitEnd)) begin
        if (r_to == TW'(TIMEOUT_CYC - 1)) begin
          r_go       <= 1'b0;
          r_done     <= r_gnt;
          r_err      <= r_gnt;
          r_wait_end <= 1'b1;
          r_state    <= StResp;
        end else begin
          r_to <= r_to + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.oGNT       = r_gnt;
  assign bus.oDONE      = r_done;
  assign bus.oERR       = r_err;
  assign bus.oRDATA     = r_rdata;
  assign bus.oBUSY      = r_busy;
  assign bus.oENG_GO    = r_go;
  assign bus.oENG_WR    = r_wr;
  assign bus.oENG_WDATA = r_wdata;
endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// Self-checking bench for sccb_bus_arbiter: vector table, corner sequences,
// and randomized transactions against a round-robin reference model.
module tb_sccb_bus_arbiter;
  localparam int N    = 2;
  localparam int MAXR = 3;
  localparam int GAP  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  sccb_bus_arbiter #(
    .NUM_REQ(N), .MAX_RETRY(MAXR), .GAP_CYC(GAP), .TIMEOUT_CYC(100)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine model: answers NACK for the first cfg_nacks attempts of a transaction.
  int       txn_id = 0;
  int       cfg_nacks = 0;
  logic [7:0] eng_rd = 8'h00;
  int       e_len = 3;
  bit       e_stuck = 1'b0;
  int       e_seen = 0, e_attempt = 0, e_cnt = 0;
  bit       e_busy = 1'b0, e_wait_low = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      e_busy = 1'b0; e_wait_low = 1'b0;
      bus.iENG_END = 1'b1; bus.iENG_ACK = 1'b0; bus.iENG_RDATA = 8'h00;
    end else begin
      if (txn_id != e_seen) begin e_seen = txn_id; e_attempt = 0; end
      if (e_busy) begin
        if (!e_stuck) begin
          if (e_cnt == 0) begin
            bus.iENG_END = 1'b1;
            bus.iENG_ACK = (e_attempt < cfg_nacks);
            bus.iENG_RDATA = eng_rd;
            e_attempt++;
            e_busy = 1'b0; e_wait_low = 1'b1;
          end else e_cnt--;
        end
      end else if (e_wait_low) begin
        if (!bus.oENG_GO) e_wait_low = 1'b0;
      end else if (bus.oENG_GO) begin
        e_busy = 1'b1; e_cnt = e_len; bus.iENG_END = 1'b0;
      end
    end
  end

  // Observed results of the last transaction.
  logic [1:0]  o_gnt, o_done;
  logic        o_err, o_ok, o_busy;
  int          o_pulses, o_gap, o_lat;
  logic [7:0]  o_rdata;
  logic [23:0] o_wd;

  task automatic run_txn(input logic [1:0] req, input logic [23:0] d0, input logic [23:0] d1,
                         input logic [1:0] wr, input int nacks, input logic [7:0] rd,
                         input bit hold);
    int low; bit goprev;
    txn_id++; cfg_nacks = nacks; eng_rd = rd;
    @(negedge clk);
    bus.iREQ = req; bus.iWDATA = {d1, d0}; bus.iWR = wr;
    o_gnt = '0; o_done = '0; o_err = 1'b0; o_ok = 1'b0; o_pulses = 0; o_gap = 1000000;
    o_lat = -1; o_rdata = '0; o_wd = '0; low = 0; goprev = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      if (o_gnt == 0) o_gnt = bus.oGNT;
      if (bus.oENG_GO && !goprev) begin
        o_pulses++;
        if (o_pulses == 1) begin o_lat = c; o_wd = bus.oENG_WDATA; end
        else if (low < o_gap) o_gap = low;
      end
      if (!bus.oENG_GO) low++; else low = 0;
      goprev = bus.oENG_GO;
      if (|bus.oDONE) begin
        o_ok = 1'b1; o_done = bus.oDONE; o_err = |bus.oERR; o_rdata = bus.oRDATA;
        if (bus.oERR != 0 && bus.oERR != bus.oDONE) o_err = 1'bx;
        break;
      end
    end
    check("done_seen", o_ok, 1'b1);
    if (!hold) bus.iREQ = '0;
    @(negedge clk);
    o_busy = bus.oBUSY;
  endtask

  typedef struct {
    logic [1:0] req; logic [23:0] d0; logic [23:0] d1; logic [1:0] wr;
    int nacks; logic [7:0] rd;
    logic [1:0] gnt; int pulses; logic err; logic [7:0] rdata; logic [23:0] wd;
  } vec_t;
  vec_t tbl[7];

  // Reference model state for the random phase.
  int         m_ptr;
  logic [7:0] m_rdata;

  initial begin
    rst = 1'b1;
    bus.iREQ = '0; bus.iWDATA = '0; bus.iWR = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_gnt",   bus.oGNT, 0);
    check("rst_done",  bus.oDONE, 0);
    check("rst_err",   bus.oERR, 0);
    check("rst_rdata", bus.oRDATA, 0);
    check("rst_busy",  bus.oBUSY, 0);
    check("rst_go",    bus.oENG_GO, 0);
    check("rst_wdata", {bus.oENG_WR, bus.oENG_WDATA}, 0);

    //          req    d0          d1          wr    nk rd      gnt   p  err rdata  wd
    tbl[0] = '{2'b01, 24'h421280, 24'h000000, 2'b01, 0, 8'h00, 2'b01, 1, 0, 8'h00, 24'h421280};
    tbl[1] = '{2'b01, 24'h420A00, 24'h000000, 2'b00, 0, 8'h76, 2'b01, 1, 0, 8'h76, 24'h420A00};
    tbl[2] = '{2'b01, 24'h421101, 24'h000000, 2'b01, 0, 8'h11, 2'b01, 1, 0, 8'h76, 24'h421101};
    tbl[3] = '{2'b10, 24'h000000, 24'h423B05, 2'b10, 2, 8'h00, 2'b10, 3, 0, 8'h76, 24'h423B05};
    tbl[4] = '{2'b10, 24'h000000, 24'h423C06, 2'b10, 9, 8'h00, 2'b10, 4, 1, 8'h76, 24'h423C06};
    tbl[5] = '{2'b11, 24'h123456, 24'hABCDEF, 2'b11, 0, 8'h00, 2'b01, 1, 0, 8'h76, 24'h123456};
    tbl[6] = '{2'b11, 24'h123456, 24'hABCDEF, 2'b11, 0, 8'h00, 2'b10, 1, 0, 8'h76, 24'hABCDEF};

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].wr, tbl[i].nacks, tbl[i].rd, 1'b0);
      check($sformatf("v%0d_gnt", i),    o_gnt, tbl[i].gnt);
      check($sformatf("v%0d_done", i),   o_done, tbl[i].gnt);
      check($sformatf("v%0d_pulses", i), o_pulses, tbl[i].pulses);
      check($sformatf("v%0d_err", i),    o_err, tbl[i].err);
      check($sformatf("v%0d_rdata", i),  o_rdata, tbl[i].rdata);
      check($sformatf("v%0d_wdata", i),  o_wd, tbl[i].wd);
      check($sformatf("v%0d_lat", i),    o_lat, 2);
      check($sformatf("v%0d_busy", i),   o_busy, 0);
      if (tbl[i].pulses > 1) check($sformatf("v%0d_gap", i), (o_gap >= GAP), 1);
    end

    // Requests held high through four transactions: strict alternation.
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 24'h111111, 24'h222222, 2'b11, 0, 8'h00, (i < 3));
      check($sformatf("rr%0d_gnt", i), o_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_wd", i),  o_wd, (i % 2 == 0) ? 24'h111111 : 24'h222222);
    end

    // Random transactions vs. a round-robin / retry model.
    m_ptr = 0; m_rdata = 8'h76;
    for (int t = 0; t < 30; t++) begin
      logic [1:0] req, wr; logic [23:0] d0, d1; logic [7:0] rd; int nk, k, expp;
      req = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(0, 3));
      d0 = 24'($urandom); d1 = 24'($urandom); rd = 8'($urandom);
      nk = $urandom_range(0, 5);
      k = req[m_ptr] ? m_ptr : 1 - m_ptr;
      m_ptr = (k + 1) % N;
      expp = ((nk < MAXR) ? nk : MAXR) + 1;
      if (!wr[k]) m_rdata = rd;
      run_txn(req, d0, d1, wr, nk, rd, 1'b0);
      check($sformatf("r%0d_gnt", t),    o_gnt, 2'b01 << k);
      check($sformatf("r%0d_pulses", t), o_pulses, expp);
      check($sformatf("r%0d_err", t),    o_err, (nk > MAXR));
      check($sformatf("r%0d_rdata", t),  o_rdata, m_rdata);
      check($sformatf("r%0d_wd", t),     o_wd, (k == 0) ? d0 : d1);
      check($sformatf("r%0d_lat", t),    o_lat, 2);
    end

    // Reset while the engine is mid-transfer.
    begin
      int dones; bit seen;
      e_len = 20; txn_id++; cfg_nacks = 0;
      @(negedge clk);
      bus.iREQ = 2'b01; bus.iWR = 2'b01; bus.iWDATA = {24'h0, 24'h425555};
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = bus.oENG_GO && !bus.iENG_END;
      end
      check("rstmid_reached", seen, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_go",   bus.oENG_GO, 0);
      check("rstmid_gnt",  bus.oGNT, 0);
      check("rstmid_busy", bus.oBUSY, 0);
      bus.iREQ = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (30) begin @(negedge clk); if (|bus.oDONE) dones++; end
      check("rstmid_nodone", dones, 0);
      e_len = 3;
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    // Engine END never rises: watchdog reports an error, then blocks grants.
    begin
      int c_go, c_done, g;
      e_stuck = 1'b1; txn_id++; cfg_nacks = 0;
      @(negedge clk);
      bus.iREQ = 2'b01; bus.iWR = 2'b01;
      c_go = -1; c_done = -1;
      for (int c = 1; c < 300 && c_done < 0; c++) begin
        @(negedge clk);
        if (c_go < 0 && bus.oENG_GO) c_go = c;
        if (|bus.oDONE) begin c_done = c; check("to_err", bus.oERR, 2'b01); end
      end
      check("to_fired", (c_done > 0), 1);
      check("to_delay", (c_done - c_go >= 95) && (c_done - c_go <= 105), 1);
      g = 0;
      repeat (10) begin @(negedge clk); if (|bus.oGNT) g++; end
      check("to_blocked", g, 0);
      bus.iREQ = '0;
      e_stuck = 1'b0;
      repeat (10) @(negedge clk);
      run_txn(2'b01, 24'h420101, 24'h0, 2'b01, 0, 8'h00, 1'b0);
      check("to_recover_err", o_err, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sccb_bus_arbiter.md
Name: sccb_bus_arbiter

Overview:
- Shares the single SCCB/I2C transaction engine (GO/WR/END/ACK handshake, 24-bit {slave, sub-addr, data} word) between NUM_REQ requesters, e.g. the boot-time camera config sequencer and the runtime exposure/gain tuner.
- Round-robin arbitration, per-transaction NACK retry, and per-requester done/error pulses.
- Sits between the requesters and the transaction engine; all logic runs on the system clock.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_RETRY, 3, relaunches allowed after a NACK before the transaction is reported as failed.
- GAP_CYC, 16, clocks GO is held low between a NACK and its relaunch (≥ 2 engine-enable periods in the integrated design).
- TIMEOUT_CYC, 2_000_000, watchdog limit in clocks; used only with SCCB_ARB_TIMEOUT_EN.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset, asynchronous, active-high.
- iREQ  in  NUM_REQ  per-requester request level.
- iWDATA  in  24*NUM_REQ  per-requester {slave, sub, data}; requester k uses bits [24k+23:24k].
- iWR  in  NUM_REQ  per-requester 1=write, 0=read.
- oGNT  out  NUM_REQ  one-hot grant, high for the whole transaction.
- oDONE  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- oERR  out  NUM_REQ  one-cycle pulse, coincident with oDONE, on failure.
- oRDATA  out  8  read byte, valid on oDONE when the transaction was a read.
- oBUSY  out  1  high in any state other than IDLE.
- oENG_GO  out  1  engine start.
- oENG_WR  out  1  engine write/read select.
- oENG_WDATA  out  24  engine data word.
- iENG_END  in  1  engine idle/finished (low while a transfer is running).
- iENG_ACK  in  1  engine ack status, 1 = NACK.
- iENG_RDATA  in  8  engine read byte.

Behaviour:
- Reset (async, iRST=1): all outputs 0; state IDLE; RR pointer 0; retry count 0. Asserting iRST mid-transfer drops oENG_GO immediately. No oDONE is issued for the aborted transfer.
- IDLE:
  - When any iREQ is high, choose the first set bit searching from pointer p upward, wrapping modulo NUM_REQ.
  - Latch that requester's iWDATA and iWR into oENG_WDATA and oENG_WR.
  - Next cycle: oGNT[k]=1 and state goes to LAUNCH.
  - Set p = (k+1) mod NUM_REQ.
- LAUNCH: oENG_GO=1. On iENG_END=0, go to WAIT_END. While iENG_END stays 1, hold GO; there is no time limit unless the timeout feature is enabled.
- WAIT_END: on iENG_END=1, drop oENG_GO and capture iENG_ACK and iENG_RDATA.
  - ACK=0: go to RESP (success).
  - ACK=1 and retry < MAX_RETRY: retry++ and go to GAP.
  - ACK=1 and retry = MAX_RETRY: go to RESP (error).
- GAP: GO low for GAP_CYC clocks, then go to LAUNCH with the latched data unchanged.
- RESP (1 cycle):
  - oDONE[k]=1; oERR[k]=1 on failure.
  - oRDATA updates only for reads, otherwise holds.
  - oGNT cleared, retry=0, next state IDLE.
- Latency: iREQ high → oENG_GO high = 2 clocks.
- Requester data is sampled once, at selection. Changes to iWDATA afterwards are ignored.
- iREQ dropped while granted: the transaction still completes and oDONE is still pulsed.
- Requester must drop iREQ in the cycle after oDONE. If it is still high, it is treated as a new request, subject to round-robin.
- Simultaneous requests: the RR pointer guarantees a requester waits at most NUM_REQ-1 transactions.
- oGNT, oDONE and oERR are always one-hot or zero.

Optional Feature:
- Macro SCCB_ARB_TIMEOUT_EN, defined:
  - A counter clears on entry to LAUNCH and increments in LAUNCH and WAIT_END.
  - At TIMEOUT_CYC it forces oENG_GO=0 and goes to RESP with oERR=1, without retrying.
  - The arbiter then waits in IDLE until iENG_END=1 before the next grant.
- Macro undefined: no counter; LAUNCH and WAIT_END wait indefinitely.

Test Plan:
- Single write: iREQ[0]=1, iWDATA0=24'h42_12_80, iWR0=1. Engine model acks → oENG_GO 2 clocks later with oENG_WDATA=24'h421280; oDONE[0] pulse; oERR=0; oBUSY low 1 clock after RESP.
- Round-robin: iREQ=2'b11 held through both transfers → grants in order 0, 1, 0, 1. After each oDONE the other requester wins, and no requester is granted twice in a row.
- NACK retry: engine returns ACK=1 twice, then 0 → 3 GO pulses, separated by ≥ GAP_CYC clocks of GO low; oDONE[1] with oERR[1]=0.
- Persistent NACK, MAX_RETRY=3 → exactly 4 GO pulses, then oDONE and oERR pulse together.
- Read: iWR0=0, engine returns iENG_RDATA=8'h76 → oRDATA=8'h76 on oDONE[0]; a following write leaves oRDATA at 8'h76.
- Reset mid-transfer: iRST pulsed while in WAIT_END → oENG_GO, oGNT and oBUSY are 0 asynchronously, with no oDONE. With SCCB_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, an engine whose END never rises → oERR after 100 clocks.
